// File: rtl/dcm_supervisor.sv
// Supervisor for the clock-synthesis DCM: sequences DCM reset pulses and lock acquisition,
// watches for lock loss or stopped clocks, and holds CLKFX-domain reset until the clock is stable.
//
// state     | meaning
// HOLD      | DCM_RST asserted for RST_CYCLES
// WAIT_LOCK | DCM released, waiting for synced LOCKED (times out into a retry)
// SETTLE    | lock seen, counting SETTLE_CYCLES clean cycles
// RUN       | clock stable, downstream reset released
module dcm_supervisor #(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 262144,
  parameter int SETTLE_CYCLES = 16,
  parameter int MAX_RETRY     = 7
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DCM_LOCKED,
  input  logic [7:0] DCM_STATUS,
  input  logic       RELOCK_REQ,
  output logic       DCM_RST,
  output logic       SYS_RESET,
  output logic       READY,
  output logic [1:0] STATE,
  output logic [3:0] RETRY_CNT,
  output logic       FAILED,
  output logic [7:0] LOSS_CNT
);

  localparam int TMAX = (LOCK_TIMEOUT > RST_CYCLES) ?
                        ((LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES) :
                        ((RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES);
  localparam int TW = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    S_HOLD      = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_SETTLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [3:0]    retry_cnt, retry_nx;
  logic          failed, failed_nx;
  logic [7:0]    loss_cnt, loss_nx;

  logic [2:0] sync1, sync2;
  logic       locked_s, stop_s;
  logic       unused_status;

  // bit0 = LOCKED, bit1 = CLKIN stopped, bit2 = CLKFX stopped
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {DCM_STATUS[2], DCM_STATUS[1], DCM_LOCKED};
      sync2 <= sync1;
    end
  end

  assign locked_s      = sync2[0];
  assign stop_s        = sync2[1] | sync2[2];
  assign unused_status = ^{DCM_STATUS[7:3], DCM_STATUS[0]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_HOLD;
      timer     <= '0;
      retry_cnt <= '0;
      failed    <= 1'b0;
      loss_cnt  <= '0;
    end else begin
      state     <= state_nx;
      timer     <= timer_nx;
      retry_cnt <= retry_nx;
      failed    <= failed_nx;
      loss_cnt  <= loss_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    retry_nx  = retry_cnt;
    failed_nx = failed;
    loss_nx   = loss_cnt;
    unique case (state)
      S_HOLD: begin
        if (timer == TW'(RST_CYCLES - 1)) begin
          state_nx = S_WAIT_LOCK;
          timer_nx = '0;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      S_WAIT_LOCK: begin
        // lock wins over a timeout landing on the same cycle
        if (locked_s) begin
          state_nx = S_SETTLE;
          timer_nx = '0;
        end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
          state_nx = S_HOLD;
          timer_nx = '0;
          if (retry_cnt != 4'hF) retry_nx = retry_cnt + 4'd1;
          if (int'(retry_nx) >= MAX_RETRY) failed_nx = 1'b1;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      S_SETTLE: begin
        if (!locked_s || stop_s) begin
          state_nx = S_WAIT_LOCK;
          timer_nx = '0;
        end else if (timer == TW'(SETTLE_CYCLES - 1)) begin
          state_nx = S_RUN;
          timer_nx = '0;
          retry_nx = '0;
        end else begin
          timer_nx = timer + TW'(1);
        end
      end
      S_RUN: begin
        if (!locked_s || stop_s) begin
          state_nx = S_HOLD;
          timer_nx = '0;
          if (loss_cnt != 8'hFF) loss_nx = loss_cnt + 8'd1;
        end
      end
    endcase
    // a firmware re-lock leaves retry bookkeeping alone but still lets a coincident loss count
    if (RELOCK_REQ) begin
      state_nx  = S_HOLD;
      timer_nx  = '0;
      retry_nx  = retry_cnt;
      failed_nx = failed;
    end
  end

  assign DCM_RST   = (state == S_HOLD);
  assign SYS_RESET = (state != S_RUN);
  assign READY     = (state == S_RUN);
  assign STATE     = state;
  assign RETRY_CNT = retry_cnt;
  assign FAILED    = failed;
  assign LOSS_CNT  = loss_cnt;

endmodule

// File: tb/tb_dcm_supervisor.sv
// Bench for dcm_supervisor: expectations are queued with a due cycle and compared on the falling edge.
// Two instances share clock and reset; the second uses a short lock timeout for the retry sequence.
`timescale 1ns/1ps
module tb_dcm_supervisor;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;

  logic       locked_a = 1'b0, relock_a = 1'b0;
  logic [7:0] status_a = 8'h00;
  logic       dcm_rst_a, sys_reset_a, ready_a, failed_a;
  logic [1:0] state_a;
  logic [3:0] retry_a;
  logic [7:0] loss_a;

  logic       locked_t = 1'b0, relock_t = 1'b0;
  logic [7:0] status_t = 8'h00;
  logic       dcm_rst_t, sys_reset_t, ready_t, failed_t;
  logic [1:0] state_t;
  logic [3:0] retry_t;
  logic [7:0] loss_t;

  dcm_supervisor dut (
    .CLK(CLK), .RST(rst), .DCM_LOCKED(locked_a), .DCM_STATUS(status_a), .RELOCK_REQ(relock_a),
    .DCM_RST(dcm_rst_a), .SYS_RESET(sys_reset_a), .READY(ready_a), .STATE(state_a),
    .RETRY_CNT(retry_a), .FAILED(failed_a), .LOSS_CNT(loss_a)
  );

  dcm_supervisor #(.LOCK_TIMEOUT(64)) dut_t (
    .CLK(CLK), .RST(rst), .DCM_LOCKED(locked_t), .DCM_STATUS(status_t), .RELOCK_REQ(relock_t),
    .DCM_RST(dcm_rst_t), .SYS_RESET(sys_reset_t), .READY(ready_t), .STATE(state_t),
    .RETRY_CNT(retry_t), .FAILED(failed_t), .LOSS_CNT(loss_t)
  );

  always #5 CLK = ~CLK;

  // observable layout: [17] DCM_RST [16] SYS_RESET [15] READY [14:13] STATE [12:9] RETRY [8] FAILED [7:0] LOSS
  localparam logic [17:0] M_ALL  = 18'h3FFFF;
  localparam logic [17:0] M_CTRL = 18'h3E000;

  typedef struct {
    string       nm;
    int          due;
    int          w;
    logic [17:0] e;
    logic [17:0] m;
  } exp_t;

  typedef struct {
    string      nm;
    logic [7:0] status;
    bit         drop;
    int         rl;
    logic [1:0] st;
    int         inc;
  } vec_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [17:0] obs(input int w);
    if (w == 0) return {dcm_rst_a, sys_reset_a, ready_a, state_a, retry_a, failed_a, loss_a};
    return {dcm_rst_t, sys_reset_t, ready_t, state_t, retry_t, failed_t, loss_t};
  endfunction

  function automatic logic [17:0] ctrl(input logic [1:0] st);
    logic dr, sr, rd;
    dr = (st == 2'd0);
    sr = (st != 2'd3);
    rd = (st == 2'd3);
    return {dr, sr, rd, st, 13'd0};
  endfunction

  function automatic logic [17:0] pk(input logic [1:0] st, input int rt, input bit fl, input int ls);
    return ctrl(st) | {5'd0, 4'(rt), fl, 8'(ls)};
  endfunction

  task automatic expect_at(input string nm, input int dly, input int w, input logic [17:0] e,
                           input logic [17:0] m);
    sb.push_back('{nm, cyc + dly, w, e, m});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // the READY comparison doubles as the bound on the wait
  task automatic wait_ready(input string nm, input int budget);
    for (int i = 0; i < budget && !ready_a; i++) tick(1);
    expect_at(nm, 0, 0, ctrl(2'd3), M_CTRL);
  endtask

  always @(negedge CLK) begin
    exp_t        keep[$];
    logic [17:0] got;
    keep.delete();
    foreach (sb[i]) begin
      if (sb[i].due <= cyc) begin
        got = obs(sb[i].w);
        n_cmp++;
        if (sb[i].due < cyc || ((got ^ sb[i].e) & sb[i].m) != 18'd0) begin
          n_bad++;
          $display("FAIL %s dut%0d cyc %0d: got %h want %h mask %h", sb[i].nm, sb[i].w, cyc,
                   got, sb[i].e, sb[i].m);
        end
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    int   loss_m;

    vt[0] = '{"clkfx_stop",  8'h04, 1'b0, -1, 2'd0, 1};
    vt[1] = '{"clkin_stop",  8'h02, 1'b0, -1, 2'd0, 1};
    vt[2] = '{"other_bits",  8'hF9, 1'b0, -1, 2'd3, 0};
    vt[3] = '{"lock_drop",   8'h00, 1'b1, -1, 2'd0, 1};
    vt[4] = '{"relock_run",  8'h00, 1'b0,  0, 2'd0, 0};
    vt[5] = '{"relock_loss", 8'h00, 1'b1,  2, 2'd0, 1};
    vt[6] = '{"relock_first",8'h06, 1'b0,  0, 2'd0, 0};
    loss_m = 0;

    tick(3);
    expect_at("reset_a", 0, 0, pk(2'd0, 0, 0, 0), M_ALL);
    expect_at("reset_t", 0, 1, pk(2'd0, 0, 0, 0), M_ALL);
    n_cmp++;
    if (dcm_rst_a !== 1'b1 || sys_reset_a !== 1'b1 || ready_a !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl_a: dcm_rst %b sys_reset %b ready %b", dcm_rst_a, sys_reset_a, ready_a);
    end
    n_cmp++;
    if (state_a !== 2'd0 || retry_a !== 4'd0 || failed_a !== 1'b0 || loss_a !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_cnt_a: state %0d retry %0d failed %b loss %0d", state_a, retry_a, failed_a, loss_a);
    end
    tick(1);
    rst = 1'b0;

    fork
      begin
        // first lock: 8-cycle DCM_RST pulse, lock 100 cycles later, READY after 19
        expect_at("rst_pulse_last", 7, 0, pk(2'd0, 0, 0, 0), M_ALL);
        expect_at("rst_pulse_end",  8, 0, pk(2'd1, 0, 0, 0), M_ALL);
        tick(108);
        locked_a = 1'b1;
        expect_at("lock_lat_18", 18, 0, pk(2'd2, 0, 0, 0), M_ALL);
        expect_at("lock_lat_19", 19, 0, pk(2'd3, 0, 0, 0), M_ALL);
        tick(25);

        // relock from RUN, then a one-cycle lock glitch at settle count 10
        expect_at("relock_pre",    0, 0, pk(2'd3, 0, 0, 0), M_ALL);
        expect_at("relock_hold",   1, 0, pk(2'd0, 0, 0, 0), M_ALL);
        expect_at("relock_rst8",   8, 0, pk(2'd0, 0, 0, 0), M_ALL);
        expect_at("relock_wait",   9, 0, pk(2'd1, 0, 0, 0), M_ALL);
        expect_at("glitch_settle", 22, 0, pk(2'd2, 0, 0, 0), M_ALL);
        expect_at("glitch_wait",   23, 0, pk(2'd1, 0, 0, 0), M_ALL);
        expect_at("glitch_resettle", 24, 0, pk(2'd2, 0, 0, 0), M_ALL);
        expect_at("glitch_not_yet", 39, 0, pk(2'd2, 0, 0, 0), M_ALL);
        expect_at("glitch_run",    40, 0, pk(2'd3, 0, 0, 0), M_ALL);
        relock_a = 1'b1;
        tick(1);
        relock_a = 1'b0;
        tick(19);
        locked_a = 1'b0;
        tick(1);
        locked_a = 1'b1;
        tick(25);

        // single-cycle disturbances applied in RUN
        for (int v = 0; v < 7; v++) begin
          loss_m = (loss_m + vt[v].inc > 255) ? 255 : loss_m + vt[v].inc;
          expect_at(vt[v].nm, 3, 0, pk(vt[v].st, 0, 0, loss_m), M_ALL);
          status_a = vt[v].status;
          locked_a = ~vt[v].drop;
          relock_a = (vt[v].rl == 0);
          tick(1);
          status_a = 8'h00;
          locked_a = 1'b1;
          relock_a = 1'b0;
          if (vt[v].rl == 2) begin
            tick(1);
            relock_a = 1'b1;
            tick(1);
            relock_a = 1'b0;
            tick(2);
          end else begin
            tick(3);
          end
          wait_ready({vt[v].nm, "_recover"}, 80);
        end

        // repeated CLKFX-stop pulses until LOSS_CNT saturates
        for (int i = 0; i < 300; i++) begin
          loss_m = (loss_m + 1 > 255) ? 255 : loss_m + 1;
          expect_at("loss_rep", 3, 0, pk(2'd0, 0, 0, loss_m), M_ALL);
          status_a = 8'h04;
          tick(1);
          status_a = 8'h00;
          tick(3);
          wait_ready("loss_rep_recover", 80);
        end
        expect_at("loss_sat", 0, 0, pk(2'd3, 0, 0, 255), M_ALL);
        tick(2);
      end
      begin
        // timeout instance: LOCKED held low, one timeout every 72 cycles
        for (int k = 1; k <= 16; k++) begin
          expect_at("retry_tmo", 72 * k, 1, pk(2'd0, (k > 15) ? 15 : k, k >= 7, 0), M_ALL);
          expect_at("retry_pre", 72 * k - 1, 1, pk(2'd1, (k - 1 > 15) ? 15 : k - 1, (k - 1) >= 7, 0), M_ALL);
        end
        expect_at("t_pulse_last", 79, 1, pk(2'd0, 1, 0, 0), M_ALL);
        expect_at("t_pulse_end",  80, 1, pk(2'd1, 1, 0, 0), M_ALL);
        tick(1200);
        locked_t = 1'b1;
        expect_at("t_settle", 18, 1, pk(2'd2, 15, 1, 0), M_ALL);
        expect_at("t_run",    19, 1, pk(2'd3, 0, 1, 0), M_ALL);
        tick(25);
      end
    join

    n_cmp++;
    if (loss_a !== 8'd255 || ready_a !== 1'b1) begin
      n_bad++;
      $display("FAIL loss_sat_direct: loss %0d ready %b", loss_a, ready_a);
    end
    n_cmp++;
    if (failed_t !== 1'b1 || retry_t !== 4'd0 || state_t !== 2'd3) begin
      n_bad++;
      $display("FAIL t_run_direct: failed %b retry %0d state %0d", failed_t, retry_t, state_t);
    end

    // asynchronous reset between edges while in SETTLE
    expect_at("pre_rst_settle", 12, 0, pk(2'd2, 0, 0, 255), M_ALL);
    relock_a = 1'b1;
    tick(1);
    relock_a = 1'b0;
    tick(12);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dcm_rst_a !== 1'b1 || sys_reset_a !== 1'b1 || ready_a !== 1'b0 || state_a !== 2'd0) begin
      n_bad++;
      $display("FAIL async_ctrl_direct: dcm_rst %b sys_reset %b ready %b state %0d",
               dcm_rst_a, sys_reset_a, ready_a, state_a);
    end
    n_cmp++;
    if (retry_a !== 4'd0 || failed_a !== 1'b0 || loss_a !== 8'd0 || failed_t !== 1'b0) begin
      n_bad++;
      $display("FAIL async_cnt_direct: retry %0d failed %b loss %0d failed_t %b",
               retry_a, failed_a, loss_a, failed_t);
    end
    expect_at("async_rst_a", 0, 0, pk(2'd0, 0, 0, 0), M_ALL);
    expect_at("async_rst_t", 0, 1, pk(2'd0, 0, 0, 0), M_ALL);
    tick(2);
    rst = 1'b0;
    tick(2);

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: %0d expectations never compared", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcm_supervisor.md
Name: dcm_supervisor

Overview:
- Controls and monitors the clock-synthesis DCM from the DCM's own input-clock domain.
- Drives the DCM's asynchronous RST input and consumes its LOCKED and STATUS[7:0] outputs.
- Sequences reset pulses and lock acquisition, detects lock loss or stopped clocks, and retries automatically.
- Holds a system reset for downstream CLKFX-domain logic until the synthesized clock is stable.

Parameters:
- RST_CYCLES, 8: cycles DCM_RST is held high per pulse. Must be at least 3, the DCM minimum.
- LOCK_TIMEOUT, 262144: cycles allowed in WAIT_LOCK before a retry (about 10.9 ms at 24 MHz).
- SETTLE_CYCLES, 16: consecutive synced-lock cycles required before RUN.
- MAX_RETRY, 7: retry count at which FAILED asserts.

Ports:
- CLK  in  1  DCM input clock (24 MHz), free-running.
- RST  in  1  reset, asynchronous, active-high.
- DCM_LOCKED  in  1  DCM LOCKED output.
- DCM_STATUS  in  8  DCM STATUS; bit1 = CLKIN stopped, bit2 = CLKFX stopped, other bits ignored.
- RELOCK_REQ  in  1  single-cycle firmware request to re-lock the DCM.
- DCM_RST  out  1  to DCM RST.
- SYS_RESET  out  1  active-high reset for CLKFX-domain logic.
- READY  out  1  high only in RUN.
- STATE  out  2  current state: HOLD=0, WAIT_LOCK=1, SETTLE=2, RUN=3.
- RETRY_CNT  out  4  lock timeouts since last RUN, saturates at 15.
- FAILED  out  1  sticky; set when RETRY_CNT reaches MAX_RETRY.
- LOSS_CNT  out  8  lock-loss events in RUN, saturates at 255.

Behaviour:
- Reset (asynchronous, takes effect with no clock edge):
  - State = HOLD; DCM_RST=1, SYS_RESET=1, READY=0.
  - RETRY_CNT=0, LOSS_CNT=0, FAILED=0; all timers 0; synchronizer flops 0.
- All outputs are registered; DCM_RST, SYS_RESET, READY and STATE decode directly from the state register.
- Input synchronization:
  - DCM_LOCKED, DCM_STATUS[1] and DCM_STATUS[2] each pass through 2 flops before use, giving 2 cycles of latency.
  - stop_s = synced STATUS[1] OR synced STATUS[2].
- HOLD:
  - DCM_RST=1, SYS_RESET=1.
  - Timer counts from 0; at RST_CYCLES-1 go to WAIT_LOCK with the timer cleared.
  - DCM_RST is therefore high for exactly RST_CYCLES cycles per pulse.
- WAIT_LOCK:
  - DCM_RST=0, SYS_RESET=1; timer increments; stop_s is ignored.
  - If locked_s=1: go to SETTLE with the timer cleared.
  - Else if timer = LOCK_TIMEOUT-1: go to HOLD; RETRY_CNT+1 (saturating); FAILED←1 if the new RETRY_CNT ≥ MAX_RETRY.
  - If locked_s=1 on the timeout cycle, lock wins.
- SETTLE:
  - DCM_RST=0, SYS_RESET=1.
  - If locked_s=0 or stop_s=1: return to WAIT_LOCK with the timer cleared; not counted as a retry.
  - Else, after SETTLE_CYCLES consecutive clean cycles: go to RUN and clear RETRY_CNT. FAILED remains set.
- RUN:
  - DCM_RST=0, SYS_RESET=0, READY=1.
  - If locked_s=0 or stop_s=1: go to HOLD; LOSS_CNT+1 (saturating).
  - SYS_RESET and READY change on the same edge as STATE.
- RELOCK_REQ:
  - In any state, go to HOLD with the hold timer restarted.
  - Does not change RETRY_CNT or LOSS_CNT.
  - If RELOCK_REQ coincides with a loss condition in RUN, it counts as a loss (LOSS_CNT+1).
- Lock-to-ready latency:
  - From DCM_LOCKED rising in WAIT_LOCK to READY=1 is 2 (sync) + 1 + SETTLE_CYCLES cycles.
  - With defaults this is 19 cycles.
- The supervisor never stops retrying; FAILED is status only.

Test Plan:
1. Release RST; raise DCM_LOCKED 100 cycles after DCM_RST falls -> DCM_RST high exactly 8 cycles after reset release; READY=1 and SYS_RESET=0 exactly 19 cycles after LOCKED rises; RETRY_CNT=0, LOSS_CNT=0.
2. LOCK_TIMEOUT=64, DCM_LOCKED held 0 -> DCM_RST pulses 8 cycles high every 72 cycles; RETRY_CNT reads 1,2,…; FAILED rises on the 7th timeout; RETRY_CNT stops at 15. Then assert LOCKED -> RUN, RETRY_CNT=0, FAILED still 1.
3. In SETTLE, drop DCM_LOCKED for 1 cycle at settle count 10 -> STATE returns to 1 then 2; READY stays 0 until 16 clean synced cycles; RETRY_CNT unchanged.
4. In RUN, pulse DCM_STATUS[2]=1 for 1 cycle -> 3 cycles later STATE=0, SYS_RESET=1, READY=0, LOSS_CNT=1; 8-cycle DCM_RST pulse; recovery to RUN once LOCKED re-asserts. Repeat 300 times -> LOSS_CNT=255.
5. RELOCK_REQ in RUN -> HOLD next edge, 8-cycle DCM_RST pulse, LOSS_CNT unchanged. RELOCK_REQ on the same cycle that synced LOCKED falls -> LOSS_CNT+1.
6. Assert RST asynchronously mid-SETTLE, between clock edges -> DCM_RST=1, SYS_RESET=1, READY=0, STATE=0 and all counters 0 before the next CLK edge.
